tile_ext_port_bridge: RTL and testbench
=======================================

Name: tile_ext_port_bridge

Overview:
- Host-side initiator for the tile register file's external ports: drives one external write port and one external read port.
- Accepts host commands (read/write, bank, address, data) over valid/ready and issues them to the ports in order, one per cycle.
- Captures read data after a fixed port latency and returns it through a credit-protected response FIFO.
- Sits outside the tile; one instance per external read/write port pair (N_EXT_RD_PORTS / N_EXT_WR_PORTS).

Parameters:
- DATA_WIDTH, 16, register data width; matches the tile package.
- N_BANK, 4, number of register banks.
- N_BANK_SIZE, 256, registers per bank.
- RD_LATENCY, 1, cycles from ext_rd_en high to ext_rd_data valid; legal range 1..4.
- RSP_DEPTH, 4, response FIFO depth; power of two, at least 2.
- Derived: BANK_W = $clog2(N_BANK), ADDR_W = $clog2(N_BANK_SIZE), CNT_W = $clog2(RSP_DEPTH+1).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  bridge can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_bank  in  BANK_W  target bank.
- cmd_addr  in  ADDR_W  register index within the bank.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data.
- ext_wr_en  out  1  external write port strobe.
- ext_wr_bank  out  BANK_W  write bank.
- ext_wr_addr  out  ADDR_W  write address.
- ext_wr_data  out  DATA_WIDTH  write data.
- ext_rd_en  out  1  external read port strobe.
- ext_rd_bank  out  BANK_W  read bank.
- ext_rd_addr  out  ADDR_W  read address.
- ext_rd_data  in  DATA_WIDTH  read data from the tile, valid RD_LATENCY cycles after ext_rd_en.
- rd_outstanding  out  CNT_W  reads issued or queued but not yet handshaken on rsp.

Behaviour:
Reset:
- All outputs 0: cmd_ready, rsp_valid, ext_* enables and fields, rsp_rdata, rd_outstanding.
- FIFO pointers, latency shift register and credit counter cleared.
- An asserted rst_n mid-operation discards in-flight reads and queued responses; no port strobe is emitted in the cycle after deassertion.
- cmd_ready rises the first clock after rst_n deasserts.

Command acceptance:
- A command is accepted on cmd_valid & cmd_ready.
- cmd_ready = (rd_outstanding < RSP_DEPTH), registered-equivalent, and independent of cmd_valid and cmd_we.
- Writes are also blocked while credits are exhausted.

Issue:
- Accepted command in cycle t drives its port in cycle t+1: one-cycle registered stage.
- Write: ext_wr_en = 1 for exactly one cycle, with bank, addr and data registered.
- Read: ext_rd_en = 1 for exactly one cycle, with bank and addr registered.
- Only one port is strobed per cycle; command order is preserved at the ports.
- Field outputs hold their last value when the enable is low.

Read capture:
- A RD_LATENCY-deep valid shift register tracks issued reads.
- ext_rd_data is pushed into the FIFO in the cycle the shift register output is 1: cycle t+1+RD_LATENCY.

Response FIFO:
- rsp_valid = FIFO not empty; rsp_rdata = FIFO head, registered from the FIFO memory.
- Pop on rsp_valid & rsp_ready. Push and pop in the same cycle are both honoured, including when the FIFO is empty: the pushed word appears at the head the next cycle.
- The FIFO has no bypass: minimum command-to-rsp_valid latency is 2+RD_LATENCY cycles.
- Overflow is impossible by the credit rule; an assertion checks push & full never occurs.

Credits:
- rd_outstanding increments on read acceptance and decrements on rsp handshake.
- Both in the same cycle leaves it unchanged.
- Saturation at RSP_DEPTH is guaranteed by cmd_ready; it never underflows.

Ordering:
- Read-after-write to the same register is correct provided the tile makes a write visible on the next cycle; the bridge issues the read at least one cycle after the write.

Test Plan:
- Reset check: hold rst_n=0, drive cmd_valid=1 -> all outputs 0; after release, cmd_ready=1 one cycle later and no ext strobe occurs in the first cycle.
- Write issue: write bank 2, addr 0x15, data 0xBEEF at cycle t -> ext_wr_en=1 only at t+1 with fields 2/0x15/0xBEEF; ext_rd_en stays 0.
- Read-after-write (RD_LATENCY=1): write 0x1234 to bank 1/addr 7, then read the same address back-to-back -> rsp_rdata=0x1234 with rsp_valid rising 3 cycles after the read is accepted; rd_outstanding goes 1 then 0 after the handshake.
- Backpressure (RSP_DEPTH=4): rsp_ready=0, issue 6 reads -> 4 accepted, cmd_ready=0 with rd_outstanding=4; raise rsp_ready -> 4 responses drain in issue order, then the remaining 2 are accepted.
- Simultaneous push/pop: streaming reads with rsp_ready=1 -> one response per cycle, rd_outstanding steady, no bubbles; repeat at RD_LATENCY=3.
- Mid-operation reset: assert rst_n low with 3 reads in flight -> rsp_valid=0 and rd_outstanding=0 immediately; after release, no stale response ever appears.

Source files
------------

// File: rtl/tile_ext_port_bridge_if.sv
// tile_ext_port_bridge_if: host command/response channel plus the tile external read/write ports.
interface tile_ext_port_bridge_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int N_BANK      = 4,
  parameter int N_BANK_SIZE = 256,
  parameter int RSP_DEPTH   = 4
);
  localparam int BANK_W = $clog2(N_BANK);
  localparam int ADDR_W = $clog2(N_BANK_SIZE);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [BANK_W-1:0]     cmd_bank;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  ext_wr_en;
  logic [BANK_W-1:0]     ext_wr_bank;
  logic [ADDR_W-1:0]     ext_wr_addr;
  logic [DATA_WIDTH-1:0] ext_wr_data;
  logic                  ext_rd_en;
  logic [BANK_W-1:0]     ext_rd_bank;
  logic [ADDR_W-1:0]     ext_rd_addr;
  logic [DATA_WIDTH-1:0] ext_rd_data;
  logic [CNT_W-1:0]      rd_outstanding;
  modport master (
    input  cmd_valid, cmd_we, cmd_bank, cmd_addr, cmd_wdata, rsp_ready, ext_rd_data,
    output cmd_ready, rsp_valid, rsp_rdata, ext_wr_en, ext_wr_bank, ext_wr_addr, ext_wr_data,
           ext_rd_en, ext_rd_bank, ext_rd_addr, rd_outstanding
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_bank, cmd_addr, cmd_wdata, rsp_ready, ext_rd_data,
    input  cmd_ready, rsp_valid, rsp_rdata, ext_wr_en, ext_wr_bank, ext_wr_addr, ext_wr_data,
           ext_rd_en, ext_rd_bank, ext_rd_addr, rd_outstanding
  );
endinterface

// File: rtl/tile_ext_port_bridge.sv
// tile_ext_port_bridge: issues host commands to the tile external ports and returns read data through a credited FIFO.
module tile_ext_port_bridge #(
  parameter int DATA_WIDTH  = 16,
  parameter int N_BANK      = 4,
  parameter int N_BANK_SIZE = 256,
  parameter int RD_LATENCY  = 1,
  parameter int RSP_DEPTH   = 4
) (
  input logic clk,
  input logic rst_n,
  tile_ext_port_bridge_if.master br
);
  localparam int BANK_W = $clog2(N_BANK);
  localparam int ADDR_W = $clog2(N_BANK_SIZE);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  logic                  cmd_fire, rd_fire, push, pop;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [BANK_W-1:0]     wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [BANK_W-1:0]     rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [RD_LATENCY-1:0] vld_q;
  logic [PTR_W-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]      fc_q, fc_d, out_q, out_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  assign cmd_fire = br.cmd_valid & cmd_ready_q;
  assign rd_fire  = cmd_fire & ~br.cmd_we;
  assign push     = vld_q[RD_LATENCY-1];
  assign pop      = (fc_q != '0) & br.rsp_ready;
  always_comb begin
    out_d       = out_q + CNT_W'(rd_fire) - CNT_W'(pop);
    cmd_ready_d = out_d < CNT_W'(RSP_DEPTH);
    wr_en_d     = cmd_fire & br.cmd_we;
    wr_bank_d   = wr_en_d ? br.cmd_bank : wr_bank_q;
    wr_addr_d   = wr_en_d ? br.cmd_addr : wr_addr_q;
    wr_data_d   = wr_en_d ? br.cmd_wdata : wr_data_q;
    rd_en_d     = rd_fire;
    rd_bank_d   = rd_fire ? br.cmd_bank : rd_bank_q;
    rd_addr_d   = rd_fire ? br.cmd_addr : rd_addr_q;
    wp_d        = wp_q + PTR_W'(push);
    rp_d        = rp_q + PTR_W'(pop);
    fc_d        = fc_q + CNT_W'(push) - CNT_W'(pop);
    // head register: take the incoming word when it lands on the slot the head moves to
    rdata_d     = (push && rp_d == wp_q) ? br.ext_rd_data : mem[rp_d];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_bank_q   <= '0;
      rd_addr_q   <= '0;
      vld_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      fc_q        <= '0;
      out_q       <= '0;
      rdata_q     <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      vld_q[0]    <= rd_en_q;
      for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      fc_q        <= fc_d;
      out_q       <= out_d;
      rdata_q     <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= br.ext_rd_data;
  end
  assign br.cmd_ready      = cmd_ready_q;
  assign br.rsp_valid      = fc_q != '0;
  assign br.rsp_rdata      = rdata_q;
  assign br.ext_wr_en      = wr_en_q;
  assign br.ext_wr_bank    = wr_bank_q;
  assign br.ext_wr_addr    = wr_addr_q;
  assign br.ext_wr_data    = wr_data_q;
  assign br.ext_rd_en      = rd_en_q;
  assign br.ext_rd_bank    = rd_bank_q;
  assign br.ext_rd_addr    = rd_addr_q;
  assign br.rd_outstanding = out_q;
  // credits bound the FIFO, so these can only fire on a design error
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && fc_q == CNT_W'(RSP_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && out_q == '0));
  a_one_strobe:   assert property (@(posedge clk) disable iff (!rst_n) !(wr_en_q && rd_en_q));
endmodule

// File: tb/tb_tile_ext_port_bridge.sv
// tb_tile_ext_port_bridge: randomized checks of the bridge against a queue-based response model and a tile memory model.
module tb_tile_ext_port_bridge;
  typedef struct { logic [15:0] d; int av; } rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  rsp_t eq[$];
  logic [15:0] ref_mem [4][256];
  logic ex_wr = 1'b0, ex_rd = 1'b0;
  logic [1:0] ex_wb, ex_rb;
  logic [7:0] ex_wa, ex_ra;
  logic [15:0] ex_wd;
  tile_ext_port_bridge_if #(.RSP_DEPTH(4)) b1 ();
  tile_ext_port_bridge_if #(.RSP_DEPTH(8)) b3 ();
  tile_ext_port_bridge #(.RD_LATENCY(1), .RSP_DEPTH(4)) dut1 (.clk(clk), .rst_n(rst_n), .br(b1));
  tile_ext_port_bridge #(.RD_LATENCY(3), .RSP_DEPTH(8)) dut3 (.clk(clk), .rst_n(rst_n), .br(b3));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] init_val(input int b, input int a);
    return 16'((b * 256 + a) * 40503 + 12345);
  endfunction
  // tile register file: writes visible next cycle, read data RD_LATENCY cycles after the strobe
  logic filled = 1'b0;
  logic [15:0] tm1 [4][256];
  logic [15:0] tm3 [4][256];
  logic [15:0] p1;
  logic [15:0] p3 [3];
  always @(posedge clk) begin
    if (!filled) begin
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 256; a++) begin
          tm1[b][a] <= init_val(b, a);
          tm3[b][a] <= init_val(b, a);
        end
      filled <= 1'b1;
    end else begin
      if (b1.ext_wr_en) tm1[b1.ext_wr_bank][b1.ext_wr_addr] <= b1.ext_wr_data;
      if (b3.ext_wr_en) tm3[b3.ext_wr_bank][b3.ext_wr_addr] <= b3.ext_wr_data;
    end
    p1 <= tm1[b1.ext_rd_bank][b1.ext_rd_addr];
    p3[0] <= tm3[b3.ext_rd_bank][b3.ext_rd_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.ext_rd_data = p1;
  assign b3.ext_rd_data = p3[2];

  task automatic drive(input logic v, input logic we, input logic [1:0] bk, input logic [7:0] ad,
                       input logic [15:0] wd, input logic rr, output logic fire);
    logic pop;
    b1.cmd_valid = v; b1.cmd_we = we; b1.cmd_bank = bk; b1.cmd_addr = ad; b1.cmd_wdata = wd;
    b1.rsp_ready = rr;
    fire = v & b1.cmd_ready;
    pop = b1.rsp_valid & rr;
    if (pop && eq.size() > 0) void'(eq.pop_front());
    ex_wr = fire & we;
    ex_rd = fire & ~we;
    if (fire && we) begin ref_mem[bk][ad] = wd; ex_wb = bk; ex_wa = ad; ex_wd = wd; end
    if (fire && !we) begin eq.push_back('{ref_mem[bk][ad], cyc + 3}); ex_rb = bk; ex_ra = ad; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.cmd_valid = 1'b1; b1.cmd_we = 1'b1; b1.cmd_bank = 2'd3; b1.cmd_addr = 8'hff; b1.cmd_wdata = 16'hffff;
    b1.rsp_ready = 1'b1;
    b3.cmd_valid = 1'b0; b3.cmd_we = 1'b0; b3.cmd_bank = '0; b3.cmd_addr = '0; b3.cmd_wdata = '0;
    b3.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (b1.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%0b exp=0", b1.cmd_ready); end
    total++; if ({b1.rsp_valid, b1.ext_wr_en, b1.ext_rd_en} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%0b exp=0", {b1.rsp_valid, b1.ext_wr_en, b1.ext_rd_en}); end
    total++; if ({b1.ext_wr_bank, b1.ext_wr_addr, b1.ext_wr_data, b1.ext_rd_bank, b1.ext_rd_addr} !== '0) begin bad++; $display("FAIL reset_fields got=%0h exp=0", {b1.ext_wr_bank, b1.ext_wr_addr, b1.ext_wr_data, b1.ext_rd_bank, b1.ext_rd_addr}); end
    total++; if ({b1.rsp_rdata, b1.rd_outstanding} !== '0) begin bad++; $display("FAIL reset_rsp got=%0h exp=0", {b1.rsp_rdata, b1.rd_outstanding}); end
    rst_n = 1'b1;
    total++; if (b1.cmd_ready !== 1'b0) begin bad++; $display("FAIL release_ready_early got=%0b exp=0", b1.cmd_ready); end
    @(negedge clk);
    total++; if (b1.cmd_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b exp=1", b1.cmd_ready); end
    total++; if ({b1.ext_wr_en, b1.ext_rd_en} !== 2'b00) begin bad++; $display("FAIL release_strobe got=%0b exp=0", {b1.ext_wr_en, b1.ext_rd_en}); end
    b1.cmd_valid = 1'b0;
    eq.delete(); ex_wr = 1'b0; ex_rd = 1'b0;
    @(negedge clk);
    total++; if ({b1.ext_wr_en, b1.ext_rd_en} !== 2'b00) begin bad++; $display("FAIL release_strobe2 got=%0b exp=0", {b1.ext_wr_en, b1.ext_rd_en}); end
  endtask

  task automatic test_write();
    logic f;
    total++; if (b1.cmd_ready !== 1'b1) begin bad++; $display("FAIL write_ready got=%0b exp=1", b1.cmd_ready); end
    drive(1'b1, 1'b1, 2'd2, 8'h15, 16'hBEEF, 1'b1, f);
    total++; if ({b1.ext_wr_en, b1.ext_rd_en} !== 2'b10) begin bad++; $display("FAIL write_strobe got=%0b exp=10", {b1.ext_wr_en, b1.ext_rd_en}); end
    total++; if ({b1.ext_wr_bank, b1.ext_wr_addr, b1.ext_wr_data} !== {2'd2, 8'h15, 16'hBEEF}) begin bad++; $display("FAIL write_fields got=%0h exp=%0h", {b1.ext_wr_bank, b1.ext_wr_addr, b1.ext_wr_data}, {2'd2, 8'h15, 16'hBEEF}); end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 1'b1, f);
    total++; if ({b1.ext_wr_en, b1.ext_rd_en} !== 2'b00) begin bad++; $display("FAIL write_one_cycle got=%0b exp=00", {b1.ext_wr_en, b1.ext_rd_en}); end
    total++; if ({b1.ext_wr_bank, b1.ext_wr_addr, b1.ext_wr_data} !== {2'd2, 8'h15, 16'hBEEF}) begin bad++; $display("FAIL write_hold got=%0h exp=%0h", {b1.ext_wr_bank, b1.ext_wr_addr, b1.ext_wr_data}, {2'd2, 8'h15, 16'hBEEF}); end
  endtask

  task automatic test_raw();
    logic f;
    drive(1'b1, 1'b1, 2'd1, 8'h07, 16'h1234, 1'b1, f);
    drive(1'b1, 1'b0, 2'd1, 8'h07, 16'h0000, 1'b1, f);
    total++; if (f !== 1'b1) begin bad++; $display("FAIL raw_accept got=%0b exp=1", f); end
    total++; if ({b1.ext_rd_en, b1.ext_rd_bank, b1.ext_rd_addr} !== {1'b1, 2'd1, 8'h07}) begin bad++; $display("FAIL raw_rd_port got=%0h exp=%0h", {b1.ext_rd_en, b1.ext_rd_bank, b1.ext_rd_addr}, {1'b1, 2'd1, 8'h07}); end
    for (int k = 1; k <= 6; k++) begin
      total++; if (b1.rsp_valid !== (k == 3)) begin bad++; $display("FAIL raw_valid k=%0d got=%0b exp=%0b", k, b1.rsp_valid, k == 3); end
      total++; if (b1.rd_outstanding !== ((k <= 3) ? 3'd1 : 3'd0)) begin bad++; $display("FAIL raw_outstanding k=%0d got=%0d", k, b1.rd_outstanding); end
      if (k == 3) begin
        total++; if (b1.rsp_rdata !== 16'h1234) begin bad++; $display("FAIL raw_data got=%0h exp=1234", b1.rsp_rdata); end
      end
      drive(1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 1'b1, f);
    end
  endtask

  task automatic test_backpressure();
    logic f;
    int idx = 0, nr = 0, budget = 0;
    for (int k = 0; k < 12; k++) begin
      drive(idx < 6, 1'b0, 2'd3, 8'(8'h40 + idx), 16'h0000, 1'b0, f);
      if (f) idx++;
    end
    total++; if (idx != 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", idx); end
    total++; if (b1.cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b exp=0", b1.cmd_ready); end
    total++; if (b1.rd_outstanding !== 3'd4) begin bad++; $display("FAIL bp_outstanding got=%0d exp=4", b1.rd_outstanding); end
    total++; if (b1.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%0b exp=1", b1.rsp_valid); end
    while (nr < 6 && budget < 40) begin
      if (b1.rsp_valid === 1'b1) begin
        total++; if (b1.rsp_rdata !== ref_mem[3][8'h40 + nr]) begin bad++; $display("FAIL bp_order n=%0d got=%0h exp=%0h", nr, b1.rsp_rdata, ref_mem[3][8'h40 + nr]); end
        nr++;
      end
      drive(idx < 6, 1'b0, 2'd3, 8'(8'h40 + idx), 16'h0000, 1'b1, f);
      if (f) idx++;
      budget++;
    end
    total++; if (nr != 6 || idx != 6) begin bad++; $display("FAIL bp_drain got=%0d/%0d exp=6/6", nr, idx); end
  endtask

  task automatic test_stream();
    logic f, ev;
    for (int k = 0; k < 32; k++) begin
      ev = eq.size() > 0 && eq[0].av <= cyc;
      total++; if (b1.cmd_ready !== (eq.size() < 4)) begin bad++; $display("FAIL st_ready k=%0d got=%0b", k, b1.cmd_ready); end
      total++; if (b1.rd_outstanding !== 3'(eq.size())) begin bad++; $display("FAIL st_outstanding k=%0d got=%0d exp=%0d", k, b1.rd_outstanding, eq.size()); end
      total++; if (b1.rsp_valid !== ev) begin bad++; $display("FAIL st_valid k=%0d got=%0b exp=%0b", k, b1.rsp_valid, ev); end
      if (ev) begin
        total++; if (b1.rsp_rdata !== eq[0].d) begin bad++; $display("FAIL st_data k=%0d got=%0h exp=%0h", k, b1.rsp_rdata, eq[0].d); end
      end
      if (k >= 4 && k < 24) begin
        total++; if ({b1.rsp_valid, b1.rd_outstanding} !== {1'b1, 3'd3}) begin bad++; $display("FAIL st_steady k=%0d got=%0b/%0d exp=1/3", k, b1.rsp_valid, b1.rd_outstanding); end
      end
      drive(k < 24, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 16'h0000, 1'b1, f);
    end
  endtask

  task automatic test_stream_lat3();
    rsp_t q[$];
    logic ev, fire, pop;
    logic [1:0] bk;
    logic [7:0] ad;
    for (int k = 0; k < 40; k++) begin
      ev = q.size() > 0 && q[0].av <= cyc;
      total++; if (b3.cmd_ready !== 1'b1) begin bad++; $display("FAIL l3_ready k=%0d got=%0b exp=1", k, b3.cmd_ready); end
      total++; if (b3.rd_outstanding !== 4'(q.size())) begin bad++; $display("FAIL l3_outstanding k=%0d got=%0d exp=%0d", k, b3.rd_outstanding, q.size()); end
      total++; if (b3.rsp_valid !== ev) begin bad++; $display("FAIL l3_valid k=%0d got=%0b exp=%0b", k, b3.rsp_valid, ev); end
      if (ev) begin
        total++; if (b3.rsp_rdata !== q[0].d) begin bad++; $display("FAIL l3_data k=%0d got=%0h exp=%0h", k, b3.rsp_rdata, q[0].d); end
      end
      if (k >= 6 && k < 28) begin
        total++; if ({b3.rsp_valid, b3.rd_outstanding} !== {1'b1, 4'd5}) begin bad++; $display("FAIL l3_steady k=%0d got=%0b/%0d exp=1/5", k, b3.rsp_valid, b3.rd_outstanding); end
      end
      bk = 2'($urandom_range(0, 3));
      ad = 8'($urandom_range(0, 255));
      b3.cmd_valid = k < 28; b3.cmd_we = 1'b0; b3.cmd_bank = bk; b3.cmd_addr = ad; b3.rsp_ready = 1'b1;
      fire = b3.cmd_valid & b3.cmd_ready;
      pop = b3.rsp_valid;
      if (pop && q.size() > 0) void'(q.pop_front());
      if (fire) q.push_back('{init_val(int'(bk), int'(ad)), cyc + 5});
      @(negedge clk);
    end
    b3.cmd_valid = 1'b0;
  endtask

  task automatic test_random();
    logic f, ev;
    for (int k = 0; k < 270; k++) begin
      ev = eq.size() > 0 && eq[0].av <= cyc;
      total++; if (b1.cmd_ready !== (eq.size() < 4)) begin bad++; $display("FAIL rnd_ready k=%0d got=%0b", k, b1.cmd_ready); end
      total++; if (b1.rd_outstanding !== 3'(eq.size())) begin bad++; $display("FAIL rnd_outstanding k=%0d got=%0d exp=%0d", k, b1.rd_outstanding, eq.size()); end
      total++; if (b1.rsp_valid !== ev) begin bad++; $display("FAIL rnd_valid k=%0d got=%0b exp=%0b", k, b1.rsp_valid, ev); end
      if (ev) begin
        total++; if (b1.rsp_rdata !== eq[0].d) begin bad++; $display("FAIL rnd_data k=%0d got=%0h exp=%0h", k, b1.rsp_rdata, eq[0].d); end
      end
      total++; if ({b1.ext_wr_en, b1.ext_rd_en} !== {ex_wr, ex_rd}) begin bad++; $display("FAIL rnd_strobe k=%0d got=%0b exp=%0b", k, {b1.ext_wr_en, b1.ext_rd_en}, {ex_wr, ex_rd}); end
      if (ex_wr) begin
        total++; if ({b1.ext_wr_bank, b1.ext_wr_addr, b1.ext_wr_data} !== {ex_wb, ex_wa, ex_wd}) begin bad++; $display("FAIL rnd_wr_fields k=%0d got=%0h exp=%0h", k, {b1.ext_wr_bank, b1.ext_wr_addr, b1.ext_wr_data}, {ex_wb, ex_wa, ex_wd}); end
      end
      if (ex_rd) begin
        total++; if ({b1.ext_rd_bank, b1.ext_rd_addr} !== {ex_rb, ex_ra}) begin bad++; $display("FAIL rnd_rd_fields k=%0d got=%0h exp=%0h", k, {b1.ext_rd_bank, b1.ext_rd_addr}, {ex_rb, ex_ra}); end
      end
      if (k < 250)
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 9) < 6, f);
      else
        drive(1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 1'b1, f);
    end
    total++; if (b1.rd_outstanding !== 3'd0 || eq.size() != 0) begin bad++; $display("FAIL rnd_drained got=%0d/%0d exp=0/0", b1.rd_outstanding, eq.size()); end
  endtask

  task automatic test_mid_reset();
    logic f;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 2'(k), 8'(8'h80 + k), 16'h0000, 1'b0, f);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 1'b0, f);
    total++; if ({b1.rsp_valid, b1.rd_outstanding} !== {1'b1, 3'd3}) begin bad++; $display("FAIL mr_before got=%0b/%0d exp=1/3", b1.rsp_valid, b1.rd_outstanding); end
    rst_n = 1'b0;
    #1;
    total++; if ({b1.rsp_valid, b1.rd_outstanding, b1.cmd_ready} !== '0) begin bad++; $display("FAIL mr_async got=%0b/%0d/%0b exp=0/0/0", b1.rsp_valid, b1.rd_outstanding, b1.cmd_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    eq.delete(); ex_wr = 1'b0; ex_rd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 1'b1, f);
      total++; if ({b1.rsp_valid, b1.ext_rd_en, b1.rd_outstanding} !== '0) begin bad++; $display("FAIL mr_stale k=%0d got=%0b/%0b/%0d exp=0", k, b1.rsp_valid, b1.ext_rd_en, b1.rd_outstanding); end
    end
    total++; if (b1.cmd_ready !== 1'b1) begin bad++; $display("FAIL mr_ready got=%0b exp=1", b1.cmd_ready); end
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) ref_mem[b][a] = init_val(b, a);
    test_reset();
    test_write();
    test_raw();
    test_backpressure();
    test_stream();
    test_stream_lat3();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
